seq_magnitude_comparator: RTL and testbench
===========================================

# seq_magnitude_comparator

Parametrised, multi-cycle magnitude comparator for the Kolache ALU. It generalises the fixed 32-bit combinational greater-than to any width, adds signed/unsigned mode and a six-way relational opcode, and evaluates CHUNK bits per cycle from the MSB, exiting early on the first differing chunk. The ALU control sequencer drives it through a start/busy/done handshake and reads a registered result plus one-hot gt/eq/lt flags.

## Interface

- WIDTH, 32: operand width in bits; must be a multiple of CHUNK.
- CHUNK, 8: bits compared per cycle. NCHUNK = WIDTH/CHUNK chunks, indexed 0 (MSB) to NCHUNK-1 (LSB).

- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; accepted only when busy=0.
- a  input  WIDTH  operand A; sampled only on the accept edge.
- b  input  WIDTH  operand B; sampled only on the accept edge.
- signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; sampled on accept.
- op  input  3  000 EQ, 001 NE, 010 GT, 011 GE, 100 LT, 101 LE, 110/111 reserved (result=0); sampled on accept.
- busy  output  1  high while a comparison is in progress.
- done  output  1  single-cycle pulse; result and flags are updated in the same cycle.
- result  output  1  op applied to (A ? B); held until the next done.
- gt, eq, lt  output  1 each  one-hot relation of A to B; held until the next done.

## Operation

- States: IDLE, CMP, DONE.
- Reset value of every output and all internal registers is 0, including gt/eq/lt (all low before the first completion). State is IDLE.
- Accept: start=1 and busy=0 (state IDLE or DONE). Latch a, b, op, and signed_mode; set idx=0; go to CMP.
- Signed mode: invert the MSB of both latched operands at capture. The unsigned chunk compare is then exact for two's complement.
- CMP, each edge: compare chunk idx of the latched A against chunk idx of the latched B.
  - If they differ: set gt/lt from the chunk compare, go to DONE.
  - If they are equal and idx=NCHUNK-1: set eq=1, go to DONE.
  - Otherwise: idx++.
- DONE lasts exactly one cycle. done=1. In this cycle result, gt, eq, and lt already hold the new values. The next state is CMP if a start is accepted in this cycle, else IDLE.
- busy=1 only in CMP.
- start while busy=1 is ignored. It is not queued, and the operands in flight are unaffected.
- Input changes outside the accept edge have no effect.
- result mapping:
  - EQ = eq
  - NE = !eq
  - GT = gt
  - GE = gt|eq
  - LT = lt
  - LE = lt|eq
  - reserved = 0. The flags are still updated for reserved opcodes.
- rst has priority over everything, including mid-CMP and a coincident start. It aborts the operation with no done pulse and clears all outputs.

## Timing

- Accept at edge E0. Chunk k is compared at edge E0+1+k.
- Let k* be the first differing chunk, or NCHUNK-1 if all chunks are equal.
  - done is high in the cycle after edge E0+1+k*.
  - Latency from the accept edge is k*+1 cycles: minimum 1, maximum NCHUNK (4 at the defaults).
- Throughput: a new start may be accepted in the done cycle. That gives back-to-back operations with no IDLE gap.
- busy rises in the cycle after E0 and falls in the done cycle.
- Degenerate CHUNK=WIDTH: latency is always 1. The handshake is unchanged.

## Test plan

- Reset, then A=B=0xFFFFFFFF, unsigned, op=GE → done 4 cycles after accept; eq=1, gt=lt=0, result=1. A=B=0, op=EQ → same latency; result=1.
- A=9, B=2, unsigned, op=GT → chunks 0–2 equal, decided at chunk 3; done 4 cycles after accept; gt=1, result=1. A=1, B=2, op=LE → lt=1, result=1.
- A=0xFF98967F, B=0xFB98967F, unsigned, op=EQ → decided at chunk 0; done 1 cycle after accept; gt=1, result=0.
- A=0x80000000, B=0x00000001, op=GT → unsigned: gt=1, result=1; signed: lt=1, result=0. Both have 1-cycle latency.
- Start at accept, then pulse start again with new operands while busy=1 → ignored; exactly one done, carrying the original operands' result. Then assert start in the done cycle → accepted; second done follows with no IDLE cycle.
- Assert rst during CMP (A=B=0x12345678, 2 cycles after accept) → next cycle: state IDLE, busy/done/result/gt/eq/lt all 0; no done pulse. Next start completes normally.

Source files
------------

// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle magnitude comparator: walks CHUNK-bit slices from the MSB and
// stops at the first differing slice, reporting one-hot gt/eq/lt plus an op-selected result.
module seq_magnitude_comparator #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  input  logic [2:0]       op,
  output logic             busy,
  output logic             done,
  output logic             result,
  output logic             gt,
  output logic             eq,
  output logic             lt,
  output logic [1:0]       dbg_state
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

  localparam logic [2:0] OP_EQ = 3'b000;
  localparam logic [2:0] OP_NE = 3'b001;
  localparam logic [2:0] OP_GT = 3'b010;
  localparam logic [2:0] OP_GE = 3'b011;
  localparam logic [2:0] OP_LT = 3'b100;
  localparam logic [2:0] OP_LE = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Handshake: a request is taken on any rising edge where start=1 and busy=0;
  // done is a one-cycle pulse whose cycle already shows the new result/flags,
  // and a start in that same cycle is taken with no idle gap.

  state_t          state, state_nxt;
  logic [WIDTH-1:0] a_q, b_q;
  logic [2:0]      op_q;
  logic [IW-1:0]   idx;
  logic [CHUNK-1:0] chunk_a, chunk_b;
  logic            accept, last, differ;
  int              base;

  function automatic logic rel_result(input logic [2:0] o, input logic g,
                                      input logic e, input logic l);
    case (o)
      OP_EQ:   rel_result = e;
      OP_NE:   rel_result = !e;
      OP_GT:   rel_result = g;
      OP_GE:   rel_result = g | e;
      OP_LT:   rel_result = l;
      OP_LE:   rel_result = l | e;
      default: rel_result = 1'b0;
    endcase
  endfunction

  always_comb begin
    base      = (NCHUNK - 1 - int'(idx)) * CHUNK;
    chunk_a   = a_q[base +: CHUNK];
    chunk_b   = b_q[base +: CHUNK];
    differ    = (chunk_a != chunk_b);
    last      = (idx == IW'(NCHUNK - 1));
    accept    = start && (state != CMP);
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CMP;
      CMP:     if (differ || last) state_nxt = DONE;
      DONE:    state_nxt = start ? CMP : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= '0;
      idx    <= '0;
      result <= 1'b0;
      gt     <= 1'b0;
      eq     <= 1'b0;
      lt     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        // Flipping the sign bit maps two's complement onto unsigned order.
        a_q  <= signed_mode ? (a ^ MSB_MASK) : a;
        b_q  <= signed_mode ? (b ^ MSB_MASK) : b;
        op_q <= op;
        idx  <= '0;
      end else if (state == CMP) begin
        if (differ) begin
          gt     <= (chunk_a > chunk_b);
          lt     <= (chunk_a < chunk_b);
          eq     <= 1'b0;
          result <= rel_result(op_q, chunk_a > chunk_b, 1'b0, chunk_a < chunk_b);
        end else if (last) begin
          gt     <= 1'b0;
          lt     <= 1'b0;
          eq     <= 1'b1;
          result <= rel_result(op_q, 1'b0, 1'b1, 1'b0);
        end else begin
          idx <= idx + 1'b1;
        end
      end
    end
  end

  assign busy      = (state == CMP);
  assign done      = (state == DONE);
  assign dbg_state = state;

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Bench for seq_magnitude_comparator: directed spec scenarios plus random
// operations scored against an arithmetic reference model.
module tb_seq_magnitude_comparator;
  localparam int WIDTH  = 32;
  localparam int CHUNK  = 8;
  localparam int NCHUNK = WIDTH / CHUNK;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a, b;
  logic             signed_mode;
  logic [2:0]       op;
  logic             busy, done, result, gt, eq, lt;
  logic [1:0]       dbg_state;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];  // {latency[3:0], result, gt, eq, lt}

  seq_magnitude_comparator #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .signed_mode(signed_mode), .op(op), .busy(busy), .done(done),
    .result(result), .gt(gt), .eq(eq), .lt(lt), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [7:0] model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                                       input logic ms, input logic [2:0] mo);
    logic g, e, l, r;
    int   kstar;
    logic [WIDTH-1:0] x;
    g = ms ? ($signed(ma) > $signed(mb)) : (ma > mb);
    l = ms ? ($signed(ma) < $signed(mb)) : (ma < mb);
    e = (ma == mb);
    case (mo)
      3'd0: r = e;
      3'd1: r = !e;
      3'd2: r = g;
      3'd3: r = g || e;
      3'd4: r = l;
      3'd5: r = l || e;
      default: r = 1'b0;
    endcase
    x = ma ^ mb;
    kstar = NCHUNK - 1;
    for (int k = NCHUNK - 1; k >= 0; k--)
      if (((x >> ((NCHUNK - 1 - k) * CHUNK)) & {{(WIDTH-CHUNK){1'b0}}, {CHUNK{1'b1}}}) != '0)
        kstar = k;
    return {4'(kstar + 1), r, g, e, l};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst = 1'b1; start = 1'b0; a = '0; b = '0; signed_mode = 1'b0; op = 3'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
  endtask

  // Called in the low phase; returns at the negedge after the accept edge.
  task automatic issue(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                       input logic is, input logic [2:0] io);
    a = ia; b = ib; signed_mode = is; op = io; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    a = $urandom; b = $urandom; signed_mode = $urandom_range(0, 1); op = 3'($urandom_range(0, 7));
    exp_q.push_back(model(ia, ib, is, io));
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || dbg_state !== 2'd1) begin
      errors++;
      $display("FAIL accept_busy: busy=%b done=%b state=%0d required busy=1 done=0 state=1",
               busy, done, dbg_state);
    end
  endtask

  // Scoreboard: counts edges since accept until done, then checks against exp_q.
  task automatic wait_done(input int pre);
    int lat;
    logic [7:0] e;
    lat = pre;
    while (1) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (done) break;
      if (lat > NCHUNK + 3) break;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL done_timeout: no done after %0d cycles", lat);
      return;
    end
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_done: done=1 with no outstanding operation");
      return;
    end
    e = exp_q.pop_front();
    if (lat !== int'(e[7:4]) || result !== e[3] || gt !== e[2] || eq !== e[1] ||
        lt !== e[0] || busy !== 1'b0) begin
      errors++;
      $display("FAIL done_values: lat=%0d res=%b gt=%b eq=%b lt=%b busy=%b required lat=%0d res=%b gt=%b eq=%b lt=%b busy=0",
               lat, result, gt, eq, lt, busy, e[7:4], e[3], e[2], e[1], e[0]);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 1'b0 || gt !== 1'b0 ||
        eq !== 1'b0 || lt !== 1'b0 || dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b res=%b gt=%b eq=%b lt=%b state=%0d required all 0",
               busy, done, result, gt, eq, lt, dbg_state);
    end
  endtask

  task automatic test_directed();
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 3'd3); wait_done(0);
    issue(32'h0, 32'h0, 1'b0, 3'd0);                 wait_done(0);
    issue(32'd9, 32'd2, 1'b0, 3'd2);                 wait_done(0);
    issue(32'd1, 32'd2, 1'b0, 3'd5);                 wait_done(0);
    issue(32'hFF98_967F, 32'hFB98_967F, 1'b0, 3'd0); wait_done(0);
    issue(32'h8000_0000, 32'h0000_0001, 1'b0, 3'd2); wait_done(0);
    issue(32'h8000_0000, 32'h0000_0001, 1'b1, 3'd2); wait_done(0);
    issue(32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b1, 3'd4); wait_done(0);
    issue(32'h0000_0100, 32'h0000_0200, 1'b0, 3'd6); wait_done(0);
  endtask

  task automatic test_ignored_start();
    int extra;
    issue(32'h1234_5678, 32'h1234_5678, 1'b0, 3'd3);
    a = 32'h0; b = 32'h1; op = 3'd0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL ignored_start_busy: busy=%b done=%b required busy=1 done=0", busy, done);
    end
    wait_done(1);
    extra = 0;
    repeat (6) begin
      @(negedge clk);
      if (done) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL ignored_start_extra_done: extra=%0d required 0", extra);
    end
  endtask

  task automatic test_back_to_back();
    issue(32'h0011_2233, 32'h0022_2233, 1'b0, 3'd4);
    wait_done(0);
    issue(32'h7F00_0000, 32'h8000_0000, 1'b1, 3'd3);  // taken on the done edge
    wait_done(0);
    issue(32'h5555_5555, 32'h5555_5555, 1'b1, 3'd1);
    wait_done(0);
  endtask

  task automatic test_mid_reset();
    int seen;
    issue(32'h8000_0000, 32'h0000_0001, 1'b0, 3'd2);
    wait_done(0);
    issue(32'h1234_5678, 32'h1234_5678, 1'b0, 3'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 1'b0 || gt !== 1'b0 ||
        eq !== 1'b0 || lt !== 1'b0 || dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL mid_reset_clear: busy=%b done=%b res=%b gt=%b eq=%b lt=%b state=%0d required all 0",
               busy, done, result, gt, eq, lt, dbg_state);
    end
    rst = 1'b0;
    exp_q.delete();
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (done) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL mid_reset_no_done: done pulses=%0d required 0", seen);
    end
    issue(32'h1234_5678, 32'h1234_5679, 1'b0, 3'd5);
    wait_done(0);
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] ra, rb;
    for (int n = 0; n < 60; n++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rb = ra;
        1: rb = ra ^ (32'h1 << $urandom_range(0, WIDTH - 1));
        2: rb = {ra[WIDTH-1:CHUNK], 8'($urandom)};
        default: rb = $urandom;
      endcase
      issue(ra, rb, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
      wait_done(0);
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_directed();
    test_ignored_start();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
